// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of every bus signal around mem_port_arbiter: the fetch requester,
// the LSU requester, the shared memory port and the status outputs.
//
//   slave  : the arbiter's view (requests/memory responses in, grants/
//            responses/memory requests out)
//   master : the surroundings' view (requesters plus memory), i.e. the
//            mirror of slave
//
// Parameters must match the ones given to mem_port_arbiter.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    // fetch side
    logic              instr_req_in;
    logic [ADDR_W-1:0] instr_addr_in;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [DATA_W-1:0] instr_rdata_o;

    // LSU side
    logic              data_req_in;
    logic [ADDR_W-1:0] data_add_in;
    logic              data_we_in;
    logic [3:0]        data_be_in;
    logic [DATA_W-1:0] data_wdata_in;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [DATA_W-1:0] data_rdata_o;

    // unified memory port
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_add_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_in;
    logic              mem_rvalid_in;
    logic [DATA_W-1:0] mem_rdata_in;

    // status
    logic [CNT_W-1:0]  outst_cnt_o;
    logic              err_o;

    modport slave (
        input  instr_req_in, instr_addr_in,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_in, data_add_in, data_we_in, data_be_in, data_wdata_in,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_add_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_in, mem_rvalid_in, mem_rdata_in,
        output outst_cnt_o, err_o
    );

    modport master (
        output instr_req_in, instr_addr_in,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_in, data_add_in, data_we_in, data_be_in, data_wdata_in,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_add_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_in, mem_rvalid_in, mem_rdata_in,
        input  outst_cnt_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between the fetch stage (source 0)
// and the LSU (source 1). Requests pass through combinationally; every
// accepted request pushes its source ID into an in-order FIFO, and every
// memory response pops the FIFO head to route the response back.
// The LSU normally wins contention, but after STARVE_LIMIT consecutive data
// grants with a fetch waiting, the fetch is forced through.
//
// Ports:
//   req    : clock, rising edge
//   reset  : synchronous, active-low reset
//   bus    : mem_port_arbiter_if.slave (fetch, LSU, memory and status signals)
//
// FSM states:
//   state       | meaning
//   ST_IDLE     | free choice of source each cycle, subject to FIFO full
//   ST_WAIT_GNT | request issued but not accepted; source locked until gnt
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             req,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_GNT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              lock_src_q, lock_src_d;

    logic [MAX_OUTST-1:0] src_fifo_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [STV_W-1:0]     starve_q;
    logic                 err_q;

    logic              sel_vld;
    logic              sel_src;
    logic              fifo_full;
    logic              fifo_empty;
    logic              starved;
    logic              push;
    logic              pop;
    logic              head_src;

    logic [ADDR_W-1:0] mem_add;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTST - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign starved    = (starve_q == STV_W'(STARVE_LIMIT));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge req) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lock_src_q <= SRC_I;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: source selection and next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        sel_vld    = 1'b0;
        sel_src    = SRC_I;

        unique case (state_q)
            ST_IDLE: begin
                // Fullness is judged on the registered count, so a pop in
                // the same cycle does not free a slot until the next one.
                if (!fifo_full) begin
                    if (bus.data_req_in && !(bus.instr_req_in && starved)) begin
                        sel_vld = 1'b1;
                        sel_src = SRC_D;
                    end else if (bus.instr_req_in) begin
                        sel_vld = 1'b1;
                        sel_src = SRC_I;
                    end
                end
                if (sel_vld && !bus.mem_gnt_in) begin
                    state_d    = ST_WAIT_GNT;
                    lock_src_d = sel_src;
                end
            end
            ST_WAIT_GNT: begin
                // Slot was reserved when the request was first raised, so
                // no full check here.
                sel_vld = 1'b1;
                sel_src = lock_src_q;
                if (bus.mem_gnt_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing is requested or granted while reset is held.
        if (!reset) begin
            sel_vld = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Request path (zero-cycle pass-through)
    // ------------------------------------------------------------------
    always_comb begin
        mem_add   = bus.instr_addr_in;
        mem_we    = 1'b0;
        mem_be    = 4'hF;
        mem_wdata = '0;
        if (sel_src == SRC_D) begin
            mem_add   = bus.data_add_in;
            mem_we    = bus.data_we_in;
            mem_be    = bus.data_be_in;
            mem_wdata = bus.data_wdata_in;
        end
    end

    assign bus.mem_req_o   = sel_vld;
    assign bus.mem_add_o   = mem_add;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_be_o    = mem_be;
    assign bus.mem_wdata_o = mem_wdata;

    assign bus.instr_gnt_o = sel_vld && bus.mem_gnt_in && (sel_src == SRC_I);
    assign bus.data_gnt_o  = sel_vld && bus.mem_gnt_in && (sel_src == SRC_D);

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign push     = sel_vld && bus.mem_gnt_in;
    assign pop      = reset && bus.mem_rvalid_in && !fifo_empty;
    assign head_src = src_fifo_q[rd_ptr_q];

    assign bus.instr_rvalid_o = pop && (head_src == SRC_I);
    assign bus.data_rvalid_o  = pop && (head_src == SRC_D);
    assign bus.instr_rdata_o  = bus.mem_rdata_in;
    assign bus.data_rdata_o   = bus.mem_rdata_in;

    assign bus.outst_cnt_o = cnt_q;
    assign bus.err_o       = err_q;

    // ------------------------------------------------------------------
    // Source-ID FIFO, starvation counter, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge req) begin
        if (!reset) begin
            src_fifo_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                src_fifo_q[wr_ptr_q] <= sel_src;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push && pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            // A response with nothing outstanding is dropped and flagged.
            if (bus.mem_rvalid_in && fifo_empty) begin
                err_q <= 1'b1;
            end

            if (!bus.instr_req_in) begin
                starve_q <= '0;
            end else if (push && (sel_src == SRC_I)) begin
                starve_q <= '0;
            end else if (push && (sel_src == SRC_D) && !starved) begin
                starve_q <= starve_q + STV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MAX_OUTST    = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .req  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ireq, input logic dreq, input logic gnt,
                         input logic rv, input logic [31:0] rdata);
        bus.instr_req_in  = ireq;
        bus.data_req_in   = dreq;
        bus.mem_gnt_in    = gnt;
        bus.mem_rvalid_in = rv;
        bus.mem_rdata_in  = rdata;
    endtask

    typedef struct {
        logic        ireq, dreq, gnt, rv;
        logic [31:0] rdata;
        logic        e_mreq, e_src, e_ivld, e_dvld;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl [13];

    // behavioural reference state for the random phase
    int   q[$];
    int   lock_src;
    int   starve;
    bit   err_m;

    initial begin
        int   gpulse;
        bit   i_act, d_act;
        bit   e_vld, e_sel, e_ig, e_dg, e_iv, e_dv;
        logic [31:0] e_add, e_wd;
        logic [3:0]  e_be;
        logic        e_we;

        // test 1 (single fetch) followed by test 2 (sustained contention)
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h333,      1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h444,      1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h555,      1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h666,      1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h777,      1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h888,      1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h999,      1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hAAA,      1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBBB,      1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hCCC,      1'b0, 1'b0, 1'b1, 1'b0, 2'd0};

        bus.instr_addr_in = 32'h10;
        bus.data_add_in   = 32'h100;
        bus.data_we_in    = 1'b1;
        bus.data_be_in    = 4'h3;
        bus.data_wdata_in = 32'hCAFEF00D;

        // reset with requests already asserted: nothing may leak out
        reset = 1'b0;
        drive(1, 1, 1, 0, 0);
        #1;
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_gnts", {bus.instr_gnt_o, bus.data_gnt_o}, 0);
        tick();
        tick();
        check("rst_cnt", bus.outst_cnt_o, 0);
        check("rst_err", bus.err_o, 0);
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].ireq, tbl[i].dreq, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            #1;
            check($sformatf("v%0d_mem_req", i), bus.mem_req_o, tbl[i].e_mreq);
            check($sformatf("v%0d_instr_gnt", i), bus.instr_gnt_o,
                  tbl[i].e_mreq && tbl[i].gnt && !tbl[i].e_src);
            check($sformatf("v%0d_data_gnt", i), bus.data_gnt_o,
                  tbl[i].e_mreq && tbl[i].gnt && tbl[i].e_src);
            if (tbl[i].e_mreq) begin
                check($sformatf("v%0d_mem_add", i), bus.mem_add_o, tbl[i].e_src ? 32'h100 : 32'h10);
                check($sformatf("v%0d_mem_we", i), bus.mem_we_o, tbl[i].e_src);
                check($sformatf("v%0d_mem_be", i), bus.mem_be_o, tbl[i].e_src ? 4'h3 : 4'hF);
                check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o,
                      tbl[i].e_src ? 32'hCAFEF00D : 32'h0);
            end
            check($sformatf("v%0d_instr_rvalid", i), bus.instr_rvalid_o, tbl[i].e_ivld);
            check($sformatf("v%0d_data_rvalid", i), bus.data_rvalid_o, tbl[i].e_dvld);
            if (tbl[i].e_ivld) check($sformatf("v%0d_instr_rdata", i), bus.instr_rdata_o, tbl[i].rdata);
            if (tbl[i].e_dvld) check($sformatf("v%0d_data_rdata", i), bus.data_rdata_o, tbl[i].rdata);
            tick();
            check($sformatf("v%0d_cnt", i), bus.outst_cnt_o, tbl[i].e_cnt);
        end

        // ---------------- gnt stall (locked source) ----------------
        gpulse = 0;
        drive(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d_mem_req", k), bus.mem_req_o, 1);
            check($sformatf("stall%0d_mem_add", k), bus.mem_add_o, 32'h100);
            if (bus.data_gnt_o) gpulse++;
            tick();
        end
        drive(1, 1, 1, 0, 0);
        #1;
        check("stall3_mem_add", bus.mem_add_o, 32'h100);
        check("stall3_instr_gnt", bus.instr_gnt_o, 0);
        if (bus.data_gnt_o) gpulse++;
        check("stall_data_gnt_pulses", gpulse, 1);
        tick();
        drive(1, 0, 1, 0, 0);
        #1;
        check("stall_after_instr_gnt", bus.instr_gnt_o, 1);
        check("stall_after_mem_add", bus.mem_add_o, 32'h10);
        tick();
        check("stall_cnt", bus.outst_cnt_o, 2);

        // ---------------- full FIFO ----------------
        drive(1, 1, 1, 0, 0);
        #1;
        check("full_mem_req", bus.mem_req_o, 0);
        check("full_gnts", {bus.instr_gnt_o, bus.data_gnt_o}, 0);
        tick();
        drive(1, 1, 1, 1, 32'h77);
        #1;
        check("full_pop_mem_req", bus.mem_req_o, 0);
        check("full_pop_data_rvalid", bus.data_rvalid_o, 1);
        tick();
        check("full_pop_cnt", bus.outst_cnt_o, 1);
        drive(1, 1, 1, 0, 0);
        #1;
        check("full_next_data_gnt", bus.data_gnt_o, 1);
        tick();
        drive(0, 0, 0, 1, 32'h1);
        #1;
        check("drain0_instr_rvalid", bus.instr_rvalid_o, 1);
        tick();
        drive(0, 0, 0, 1, 32'h2);
        #1;
        check("drain1_data_rvalid", bus.data_rvalid_o, 1);
        tick();
        check("drain_cnt", bus.outst_cnt_o, 0);

        // ---------------- interleaved responses ----------------
        bus.instr_addr_in = 32'h4;
        drive(1, 0, 1, 0, 0);
        #1;
        check("il_instr_gnt", bus.instr_gnt_o, 1);
        check("il_instr_add", bus.mem_add_o, 32'h4);
        tick();
        drive(0, 1, 1, 0, 0);
        #1;
        check("il_data_gnt", bus.data_gnt_o, 1);
        tick();
        drive(0, 0, 0, 1, 32'hAAAA);
        #1;
        check("il_r0_rvalids", {bus.instr_rvalid_o, bus.data_rvalid_o}, 2'b10);
        check("il_r0_rdata", bus.instr_rdata_o, 32'hAAAA);
        tick();
        drive(0, 0, 0, 1, 32'h5555);
        #1;
        check("il_r1_rvalids", {bus.instr_rvalid_o, bus.data_rvalid_o}, 2'b01);
        check("il_r1_rdata", bus.data_rdata_o, 32'h5555);
        tick();
        check("il_cnt", bus.outst_cnt_o, 0);

        // ---------------- reset mid-operation ----------------
        drive(1, 0, 1, 0, 0);
        tick();
        check("rm_cnt_before", bus.outst_cnt_o, 1);
        reset = 1'b0;
        drive(1, 1, 1, 0, 0);
        #1;
        check("rm_mem_req_in_reset", bus.mem_req_o, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 1, 32'h99);
        #1;
        check("rm_late_rvalids", {bus.instr_rvalid_o, bus.data_rvalid_o}, 0);
        tick();
        check("rm_err", bus.err_o, 1);
        check("rm_cnt", bus.outst_cnt_o, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        check("rm_err_sticky", bus.err_o, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rm_err_cleared", bus.err_o, 0);

        // ---------------- randomized run vs reference model ----------------
        q.delete();
        lock_src = -1;
        starve   = 0;
        err_m    = 0;
        i_act    = 0;
        d_act    = 0;
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1;
                bus.instr_addr_in = $urandom;
            end
            if (!d_act && $urandom_range(0, 1) == 0) begin
                d_act = 1;
                bus.data_add_in   = $urandom;
                bus.data_we_in    = 1'($urandom_range(0, 1));
                bus.data_be_in    = 4'($urandom_range(0, 15));
                bus.data_wdata_in = $urandom;
            end
            drive(i_act, d_act, ($urandom_range(0, 9) < 6),
                  (q.size() > 0) && ($urandom_range(0, 9) < 4), $urandom);
            #1;

            // model: pick the source this cycle
            e_vld = 0;
            e_sel = 0;
            if (lock_src >= 0) begin
                e_vld = 1;
                e_sel = (lock_src == 1);
            end else if (q.size() < MAX_OUTST) begin
                if (d_act && !(i_act && starve == STARVE_LIMIT)) begin
                    e_vld = 1; e_sel = 1;
                end else if (i_act) begin
                    e_vld = 1; e_sel = 0;
                end
            end
            e_ig  = e_vld && bus.mem_gnt_in && !e_sel;
            e_dg  = e_vld && bus.mem_gnt_in && e_sel;
            e_iv  = bus.mem_rvalid_in && q.size() > 0 && q[0] == 0;
            e_dv  = bus.mem_rvalid_in && q.size() > 0 && q[0] == 1;
            e_add = e_sel ? bus.data_add_in : bus.instr_addr_in;
            e_we  = e_sel ? bus.data_we_in : 1'b0;
            e_be  = e_sel ? bus.data_be_in : 4'hF;
            e_wd  = e_sel ? bus.data_wdata_in : 32'h0;

            check("rnd_mem_req", bus.mem_req_o, e_vld);
            check("rnd_gnts", {bus.instr_gnt_o, bus.data_gnt_o}, {e_ig, e_dg});
            if (e_vld) check("rnd_req_fields", {bus.mem_add_o, bus.mem_we_o, bus.mem_be_o, bus.mem_wdata_o},
                             {e_add, e_we, e_be, e_wd});
            check("rnd_rvalids", {bus.instr_rvalid_o, bus.data_rvalid_o}, {e_iv, e_dv});
            if (e_iv || e_dv) check("rnd_rdata", {bus.instr_rdata_o, bus.data_rdata_o},
                                    {bus.mem_rdata_in, bus.mem_rdata_in});
            check("rnd_cnt", bus.outst_cnt_o, q.size());
            check("rnd_err", bus.err_o, err_m);

            // model: advance one clock
            if (bus.mem_rvalid_in) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1;
            end
            if (e_vld && bus.mem_gnt_in) begin
                q.push_back(e_sel ? 1 : 0);
                lock_src = -1;
            end else if (e_vld) begin
                lock_src = e_sel ? 1 : 0;
            end
            if (!i_act) starve = 0;
            else if (e_ig) starve = 0;
            else if (e_dg && starve < STARVE_LIMIT) starve++;
            if (e_ig) i_act = 0;
            if (e_dg) d_act = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-to-one arbiter that shares a single unified memory port between the fetch stage (instruction requester) and the LSU (data requester). All three interfaces use the req/gnt/rvalid handshake already used by instr_ram and data_ram. The block tracks in-order outstanding transactions in a source-ID FIFO and routes each response back to its originator. It prevents instruction starvation under sustained LSU traffic.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTST, 2, maximum granted-but-unanswered transactions (depth of source-ID FIFO, >=1)
STARVE_LIMIT, 4, consecutive data grants with instr pending before instr is forced to win (>=1)

Ports:
req  in  1  clock (rising edge)
reset  in  1  synchronous, active-low reset
instr_req_in  in  1  fetch request
instr_addr_in  in  ADDR_W  fetch address
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DATA_W  fetch response data
data_req_in  in  1  LSU request
data_add_in  in  ADDR_W  LSU address
data_we_in  in  1  LSU write enable
data_be_in  in  4  LSU byte enables
data_wdata_in  in  DATA_W  LSU write data
data_gnt_o  out  1  LSU request accepted
data_rvalid_o  out  1  LSU response valid
data_rdata_o  out  DATA_W  LSU response data
mem_req_o  out  1  request to memory
mem_add_o  out  ADDR_W  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_wdata_o  out  DATA_W  memory write data
mem_gnt_in  in  1  memory accepted request
mem_rvalid_in  in  1  memory response valid (one per granted request, reads and writes, in order)
mem_rdata_in  in  DATA_W  memory response data
outst_cnt_o  out  $clog2(MAX_OUTST+1)  current outstanding count
err_o  out  1  sticky: mem_rvalid_in received with empty FIFO

Behaviour:
- Reset (reset==0 at posedge): FSM=IDLE, FIFO empty, starve_cnt=0, err_o=0. All gnt/rvalid/mem_req_o outputs 0 during reset. Outstanding transactions at reset are discarded; late mem_rvalid_in after reset sets err_o.
- FSM IDLE: if outst_cnt_o==MAX_OUTST, mem_req_o=0 and no grants (also when a pop occurs the same cycle). Otherwise select a source combinationally: data only -> data; instr only -> instr; both -> data unless starve_cnt==STARVE_LIMIT, then instr. mem_req_o=1 when a source is selected. Zero-cycle pass-through of address/controls.
- Instr source drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0. Data source forwards data_we_in/data_be_in/data_wdata_in.
- Handshake: selected gnt_o = mem_gnt_in in the same cycle. Transfer occurs on mem_req_o && mem_gnt_in; the source ID (0=instr, 1=data) is pushed to the FIFO.
- If mem_req_o=1 and mem_gnt_in=0: go to WAIT_GNT, registering the selected source. In WAIT_GNT, the selection is frozen, mem_req_o stays 1 and controls track the locked source. Requesters hold their req/address until gnt. The block returns to IDLE on mem_gnt_in. The full check does not apply in WAIT_GNT, because the request was already counted as admissible.
- Response: mem_rvalid_in pops the FIFO head. The matching rvalid_o is high for that cycle; the other source's rvalid_o stays 0. mem_rdata_in is broadcast to both rdata outputs. Response latency is 0 cycles added.
- Simultaneous push and pop: the count is unchanged. The FIFO pointers wrap modulo MAX_OUTST.
- Empty pop: the response is dropped (no rvalid_o) and err_o=1 until reset.
- starve_cnt: increments (saturating at STARVE_LIMIT) on a data transfer while instr_req_in=1. It clears on an instr transfer or whenever instr_req_in=0.
- outst_cnt_o is registered and reflects pushes minus pops.

Test Plan:
1. Single fetch: instr_req_in=1, addr=0x10, mem_gnt_in=1, rvalid 1 cycle later with rdata=0x00100093 -> instr_gnt_o in cycle 0, instr_rvalid_o=1 with 0x00100093 in cycle 1, data_rvalid_o=0, outst_cnt_o 1->0.
2. Contention: both requesters held high, mem_gnt_in=1 every cycle, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I. Writes from the data side appear with mem_be_o=data_be_in; instr grants show be=4'hF, we=0.
3. Gnt stall: data request with mem_gnt_in=0 for 3 cycles, then instr_req_in rises, then gnt=1 -> mem_add_o stays at the data address for all 4 cycles and data_gnt_o pulses once. The instr request is granted afterwards.
4. Full: MAX_OUTST=2, two grants with no rvalid -> mem_req_o=0 on the third request. A pop plus a pending request in the same cycle is still blocked that cycle and granted the next.
5. Interleaved responses: grant I(0x4), D(0x100), then rvalid x2 with rdata 0xAAAA, 0x5555 -> instr_rvalid_o with 0xAAAA, then data_rvalid_o with 0x5555.
6. Reset mid-op: one outstanding, reset low 1 cycle, then mem_rvalid_in=1 -> no rvalid_o, err_o=1, outst_cnt_o=0. A second reset clears err_o.
